// File: rtl/scan_test_ctrl_pkg.sv
// Shared definitions for the scan test controller: FSM state type,
// MISR constants and the shift-counter width helper.
package scan_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CAPTURE,
    UNLOAD,
    DONE
  } state_t;

  localparam int          MISR_W    = 16;
  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  // The shift counter must be able to hold the value chain_len itself
  function automatic int shift_cnt_width(input int chain_len);
    return $clog2(chain_len + 1);
  endfunction

endpackage

// File: rtl/scan_test_ctrl_if.sv
// Host stream plus scan-chain signal bundle for scan_test_ctrl.
// Optional SCAN_MISR_EN adds the compacted signature output.
interface scan_test_ctrl_if #(
  parameter int PAT_CNT_W = 16
);
  import scan_ctrl_pkg::*;

  logic                 start;
  logic [PAT_CNT_W-1:0] num_pat;
  logic                 busy;
  logic                 done;
  logic                 pat_valid;
  logic                 pat_bit;
  logic                 pat_ready;
  logic                 resp_valid;
  logic                 resp_bit;
  logic                 resp_ready;
  logic                 SE;
  logic                 TDI;
  logic                 TDO;
  logic                 scan_ce;
`ifdef SCAN_MISR_EN
  logic [MISR_W-1:0]    signature;
`endif

  // Controller side
  modport slave (
    input  start, num_pat, pat_valid, pat_bit, resp_ready, TDO,
    output busy, done, pat_ready, resp_valid, resp_bit, SE, TDI, scan_ce
`ifdef SCAN_MISR_EN
    , output signature
`endif
  );

  // Host / scanned-core side
  modport master (
    output start, num_pat, pat_valid, pat_bit, resp_ready, TDO,
    input  busy, done, pat_ready, resp_valid, resp_bit, SE, TDI, scan_ce
`ifdef SCAN_MISR_EN
    , input signature
`endif
  );

endinterface

// File: rtl/scan_test_ctrl_misr.sv
// 16-bit serial-input MISR (x^16+x^12+x^5+1) used to compact scan
// responses when SCAN_MISR_EN is defined.
module scan_misr
  import scan_ctrl_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst,
  input  logic              clr,
  input  logic              en,
  input  logic              din,
  output logic [MISR_W-1:0] sig
);

  // Shift the signature, folding the incoming bit into the feedback tap
  always_ff @(posedge Clk) begin
    if (Rst || clr) begin
      sig <= MISR_SEED;
    end else if (en) begin
      sig <= {sig[MISR_W-2:0], 1'b0} ^
             ({MISR_W{sig[MISR_W-1] ^ din}} & MISR_POLY);
    end
  end

endmodule

// File: rtl/scan_test_ctrl.sv
// Mux-D scan chain sequencer: streams patterns in, pulses capture,
// streams responses out with shift-in/shift-out overlap.
// Define SCAN_MISR_EN to compact responses into a MISR signature.
module scan_test_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = 211,
  parameter int PAT_CNT_W = 16
) (
  input logic             Clk,
  input logic             Rst,
  scan_test_ctrl_if.slave bus
);

  localparam int CNT_W = shift_cnt_width(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(CHAIN_LEN);

`ifdef SCAN_MISR_EN
  localparam bit MISR_ON = 1'b1;
`else
  localparam bit MISR_ON = 1'b0;
`endif

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     shift_cnt_q, shift_cnt_d;
  logic [CNT_W-1:0]     shift_inc;
  logic [PAT_CNT_W-1:0] pat_cnt_q, pat_cnt_d;
  logic [PAT_CNT_W-1:0] pat_inc;
  logic [PAT_CNT_W-1:0] num_pat_q, num_pat_d;
  logic                 first_q, first_d;
  logic                 resp_ready_eff;
  logic                 shift_adv;
  logic                 unload_adv;

  // With the MISR the response side never back-pressures the chain
  assign resp_ready_eff = MISR_ON | bus.resp_ready;
  assign shift_adv  = (state_q == SHIFT) && bus.pat_valid && (first_q || resp_ready_eff);
  assign unload_adv = (state_q == UNLOAD) && resp_ready_eff;
  assign shift_inc  = shift_cnt_q + 1'b1;
  assign pat_inc    = pat_cnt_q + 1'b1;

  // State and counter registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      shift_cnt_q <= '0;
      pat_cnt_q   <= '0;
      num_pat_q   <= '0;
      first_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_cnt_q <= shift_cnt_d;
      pat_cnt_q   <= pat_cnt_d;
      num_pat_q   <= num_pat_d;
      first_q     <= first_d;
    end
  end

  // Next-state, counter updates and chain/handshake outputs
  always_comb begin
    state_d        = state_q;
    shift_cnt_d    = shift_cnt_q;
    pat_cnt_d      = pat_cnt_q;
    num_pat_d      = num_pat_q;
    first_d        = first_q;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    bus.SE         = 1'b0;
    bus.TDI        = 1'b0;
    bus.scan_ce    = 1'b0;
    bus.pat_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_bit   = bus.TDO;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          num_pat_d = bus.num_pat;
          if (bus.num_pat == '0) begin
            state_d = DONE;
          end else begin
            state_d     = SHIFT;
            shift_cnt_d = '0;
            pat_cnt_d   = '0;
            first_d     = 1'b1;
          end
        end
      end

      SHIFT: begin
        bus.busy       = 1'b1;
        bus.SE         = 1'b1;
        bus.TDI        = bus.pat_bit;
        bus.scan_ce    = shift_adv;
        bus.pat_ready  = shift_adv;
        bus.resp_valid = !MISR_ON && bus.pat_valid && !first_q;
        if (shift_adv) begin
          shift_cnt_d = shift_inc;
          if (shift_inc == LAST_SHIFT) begin
            state_d = CAPTURE;
          end
        end
      end

      CAPTURE: begin
        bus.busy    = 1'b1;
        bus.scan_ce = 1'b1;
        pat_cnt_d   = pat_inc;
        first_d     = 1'b0;
        shift_cnt_d = '0;
        state_d     = (pat_inc == num_pat_q) ? UNLOAD : SHIFT;
      end

      UNLOAD: begin
        bus.busy       = 1'b1;
        bus.SE         = 1'b1;
        bus.resp_valid = !MISR_ON;
        bus.scan_ce    = unload_adv;
        if (unload_adv) begin
          shift_cnt_d = shift_inc;
          if (shift_inc == LAST_SHIFT) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef SCAN_MISR_EN
  logic misr_clr;
  logic misr_en;

  assign misr_clr = (state_q == IDLE) && bus.start;
  assign misr_en  = (shift_adv && !first_q) || unload_adv;

  scan_misr u_misr (
    .Clk (Clk),
    .Rst (Rst),
    .clr (misr_clr),
    .en  (misr_en),
    .din (bus.TDO),
    .sig (bus.signature)
  );
`endif

endmodule

// File: tb/tb_scan_test_ctrl.sv
// Testbench for scan_test_ctrl with a 4-flop behavioural chain whose
// capture function inverts every flop. Handles SCAN_MISR_EN builds too.
module tb_scan_test_ctrl;

  localparam int L = 4;
  localparam int W = 16;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  bit   patQ[$];
  logic [L-1:0] chain;

  scan_test_ctrl_if #(.PAT_CNT_W(W)) bus ();

  scan_test_ctrl #(.CHAIN_LEN(L), .PAT_CNT_W(W)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  assign bus.TDO = chain[L-1];

  // Behavioural scanned core: shift toward TDO, or capture the inverse
  always @(posedge Clk) begin
    if (bus.scan_ce) begin
      if (bus.SE) chain <= {chain[L-2:0], bus.TDI};
      else        chain <= ~chain;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Serial MISR over the expected response stream (inverted pattern stream)
  function automatic logic [15:0] misrModel();
    logic [15:0] s = 16'hFFFF;
    logic b;
    for (int i = 0; i < patQ.size(); i++) begin
      b = ~patQ[i];
      s = (s[15] ^ b) ? ({s[14:0], 1'b0} ^ 16'h1021) : {s[14:0], 1'b0};
    end
    return s;
  endfunction

  task automatic fillRandom(input int n);
    patQ.delete();
    for (int i = 0; i < n * L; i++) patQ.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic applyStimulus(input int n, input bit stalls, input int abortCycle);
    bit   got[$];
    int   cycle = 0;
    int   si = 0;
    int   captures = 0;
    int   doneCycle = -1;
    int   rrStall = 0;
    int   pvStall = 0;
    int   unloadGot = 0;
    bit   pvNow, rrNow, sawRespValid;
    logic e, g;
    sawRespValid = 1'b0;
    @(posedge Clk); #1;
    bus.start = 1'b1; bus.num_pat = W'(n); bus.pat_valid = 1'b0; bus.resp_ready = 1'b1;
    @(posedge Clk); #1;
    bus.start = 1'b0;
    while (cycle < 200 && doneCycle < 0) begin
      pvNow = stalls && cycle >= 6 && cycle <= 8;
      rrNow = stalls && captures == n && unloadGot == 2 && rrStall < 2;
      bus.pat_valid  = (si < n * L) && !pvNow;
      bus.pat_bit    = bus.pat_valid ? patQ[si] : 1'b0;
      bus.resp_ready = !rrNow;
      if (cycle == abortCycle) begin
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0; bus.pat_valid = 1'b0;
        @(negedge Clk);
        checkOutput("abort_busy", bus.busy, 0);
        checkOutput("abort_SE", bus.SE, 0);
        checkOutput("abort_scan_ce", bus.scan_ce, 0);
        checkOutput("abort_done", bus.done, 0);
        @(posedge Clk); #1;
        @(negedge Clk);
        checkOutput("abort_no_done", bus.done, 0);
        return;
      end
      @(negedge Clk);
      if (bus.resp_valid) sawRespValid = 1'b1;
      if (pvNow) begin
        pvStall++;
        checkOutput("shift_stall_ce", bus.scan_ce, 0);
      end
      if (rrNow) begin
        rrStall++;
        checkOutput("unload_stall_ce", bus.scan_ce, 0);
      end
      if (bus.pat_ready) si++;
      if (bus.resp_valid && bus.resp_ready) begin
        got.push_back(bus.resp_bit);
        if (captures == n) unloadGot++;
      end
      if (bus.busy && bus.scan_ce && !bus.SE) begin
        if (!stalls) checkOutput("capture_cycle", cycle, captures * (L + 1) + L);
        captures++;
      end
      if (bus.done) begin
        doneCycle = cycle;
`ifdef SCAN_MISR_EN
        checkOutput("signature", bus.signature, misrModel());
`endif
      end
      @(posedge Clk); #1;
      cycle++;
    end
    if (doneCycle < 0) begin
      checkOutput("done_timeout", 0, 1);
      return;
    end
    checkOutput("done_cycle", doneCycle, n * (L + 1) + L + pvStall + rrStall);
    checkOutput("pat_ready_count", si, n * L);
    checkOutput("capture_count", captures, n);
    bus.pat_valid = 1'b0;
    @(negedge Clk);
    checkOutput("done_one_cycle", bus.done, 0);
    checkOutput("idle_busy", bus.busy, 0);
`ifdef SCAN_MISR_EN
    checkOutput("resp_valid_tied", sawRespValid, 0);
`else
    checkOutput("resp_count", got.size(), n * L);
    for (int i = 0; i < got.size() && i < patQ.size(); i++) begin
      e = ~patQ[i];
      g = got[i];
      checkOutput($sformatf("resp_bit%0d", i), g, e);
    end
`endif
  endtask

  task automatic checkZeroPatterns();
    @(posedge Clk); #1;
    bus.start = 1'b1; bus.num_pat = '0;
    @(negedge Clk);
    checkOutput("zero_busy_start", bus.busy, 0);
    @(posedge Clk); #1;
    bus.start = 1'b0;
    @(negedge Clk);
    checkOutput("zero_done", bus.done, 1);
    checkOutput("zero_busy", bus.busy, 0);
    checkOutput("zero_SE", bus.SE, 0);
    checkOutput("zero_scan_ce", bus.scan_ce, 0);
    @(posedge Clk); #1;
    @(negedge Clk);
    checkOutput("zero_done_low", bus.done, 0);
  endtask

  initial begin
    chain = 4'($urandom);
    bus.start = 1'b0; bus.num_pat = '0; bus.pat_valid = 1'b0;
    bus.pat_bit = 1'b0; bus.resp_ready = 1'b1;
    repeat (3) @(posedge Clk);
    #1 Rst = 1'b0;
    @(negedge Clk);
    checkOutput("reset_SE", bus.SE, 0);
    checkOutput("reset_TDI", bus.TDI, 0);
    checkOutput("reset_scan_ce", bus.scan_ce, 0);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_done", bus.done, 0);
    checkOutput("reset_pat_ready", bus.pat_ready, 0);
    checkOutput("reset_resp_valid", bus.resp_valid, 0);

    // Single pattern 1,0,1,1 expecting responses 0,1,0,0
    patQ = '{1'b1, 1'b0, 1'b1, 1'b1};
    applyStimulus(1, 1'b0, -1);

    // Three random patterns, clean then with stalls on the same data
    fillRandom(3);
    applyStimulus(3, 1'b0, -1);
    applyStimulus(3, 1'b1, -1);

    checkZeroPatterns();

    // Abort in the second shift phase, then a clean session
    fillRandom(3);
    applyStimulus(3, 1'b0, 7);
    fillRandom(2);
    applyStimulus(2, 1'b0, -1);

    // Two fixed patterns
    patQ = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    applyStimulus(2, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
